// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request/response handshake and a registered result.
// Define ALU_SEQ_DIV_EN to build the restoring divider for mode 111 (otherwise mode 111 returns 0, Z=1).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] AC,
  input  logic [WIDTH-1:0] DR,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             E,
  output logic             Z
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] op_rem;
  logic             op_e;
  logic [WIDTH:0]   sum;
  logic             start_div;

  // Single-cycle results, computed from the operands presented on the accepting edge.
  always_comb begin
    sum    = {1'b0, AC} + {1'b0, DR};
    op_res = '0;
    op_rem = '0;
    op_e   = 1'b0;
    case (mode)
      3'b000: begin
        op_res = sum[WIDTH-1:0];
        op_e   = sum[WIDTH];
      end
      3'b001: begin
        op_res = {DR[WIDTH-2:0], 1'b0};
        op_e   = DR[WIDTH-1];
      end
      3'b010: op_res = ~(AC ^ DR);
      3'b011: begin
        op_res = {1'b0, DR[WIDTH-1:1]};
        op_e   = DR[0];
      end
      3'b100: op_res = DR;
      3'b101: op_res = AC;
      3'b110: begin
        op_res = '0 - AC;
        op_e   = (AC == '0);
      end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        // Only the divide-by-zero case finishes here; real divisions go through BUSY.
        op_res = '1;
        op_rem = AC;
        op_e   = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] prem_nxt;

  assign start_div = (mode == 3'b111) && (DR != '0);

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    trial = {prem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      prem_nxt = trial[WIDTH-1:0];
      quo_nxt  = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      prem_nxt = diff[WIDTH-1:0];
      quo_nxt  = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      quo_q  <= AC;
      dvs_q  <= DR;
      prem_q <= '0;
      cnt_q  <= '0;
    end else if (state == BUSY) begin
      quo_q  <= quo_nxt;
      prem_q <= prem_nxt;
      cnt_q  <= cnt_q + CW'(1);
    end
  end
`else
  assign start_div = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      rem       <= '0;
      E         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (start_div) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= op_res;
              rem       <= op_rem;
              E         <= op_e;
              Z         <= (op_res == '0);
            end
          end
        end
`ifdef ALU_SEQ_DIV_EN
        BUSY: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= quo_nxt;
            rem       <= prem_nxt;
            E         <= 1'b0;
            Z         <= (quo_nxt == '0);
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random operations against an arithmetic model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   mode;
  logic [W-1:0] AC;
  logic [W-1:0] DR;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] rem;
  logic         E;
  logic         Z;

  int passed = 0;
  int total  = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .AC(AC), .DR(DR), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rem(rem), .E(E), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected outcome straight from the operation definitions, using integer arithmetic.
  task automatic model(input int m, input int a, input int d,
                       output int r, output int rm, output int e, output int lat);
    int s;
    r = 0; rm = 0; e = 0; lat = 1;
    case (m)
      0: begin s = a + d; r = s % 256; e = (s > 255) ? 1 : 0; end
      1: begin r = (d * 2) % 256; e = (d >= 128) ? 1 : 0; end
      2: r = 255 - (a ^ d);
      3: begin r = d / 2; e = d % 2; end
      4: r = d;
      5: r = a;
      6: begin r = (256 - a) % 256; e = (a == 0) ? 1 : 0; end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        if (d == 0) begin
          r = 255; rm = a; e = 1;
        end else begin
          r = a / d; rm = a % d; lat = W + 1;
        end
`else
        r = 0;
`endif
      end
    endcase
  endtask

  task automatic run_op(input string tag, input int m, input int a, input int d, input int hold);
    int er, erm, ee, elat, lat, waitc;
    model(m, a, d, er, erm, ee, elat);
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    mode = 3'(m); AC = 8'(a); DR = 8'(d); in_valid = 1'b1;
    tick();
    // Garbage requests after acceptance must be ignored.
    mode = 3'($urandom); AC = 8'($urandom); DR = 8'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      check({tag, "_busy_rdy"}, 32'(in_ready), 0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_rem"}, 32'(rem), 32'(erm));
    check({tag, "_E"}, 32'(E), 32'(ee));
    check({tag, "_Z"}, 32'(Z), (er == 0) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_vld"}, 32'(out_valid), 1);
      check({tag, "_hold_rdy"}, 32'(in_ready), 0);
      check({tag, "_hold_res"}, 32'({E, Z, rem, result}),
            32'({ee[0], (er == 0), erm[7:0], er[7:0]}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop_vld"}, 32'(out_valid), 0);
    check({tag, "_back_rdy"}, 32'(in_ready), 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = '0; AC = '0; DR = '0;

    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_outputs", 32'({E, Z, rem, result}), 0);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);

    run_op("add_f0_20", 0, 'hF0, 'h20, 0);
    run_op("div_100_7", 7, 100, 7, 0);
    run_op("div_55_0", 7, 'h55, 0, 0);
    run_op("twos_0", 6, 0, 'h33, 5);
    run_op("asl_81", 1, 'h5A, 'h81, 5);
    run_op("div_9_3", 7, 9, 3, 1);
    run_op("div_255_1", 7, 255, 1, 0);
    run_op("div_7_255", 7, 7, 255, 0);
    run_op("shr_01", 3, 0, 'h01, 0);
    run_op("xnor", 2, 'hA5, 'h5A, 0);

    // Reset in the middle of a division discards it.
    mode = 3'b111; AC = 8'd200; DR = 8'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("abort_rst_vld", 32'(out_valid), 0);
    check("abort_rst_outs", 32'({E, Z, rem, result}), 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("abort_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_valid", 32'(seen), 0);
    check("abort_outs_zero", 32'({E, Z, rem, result}), 0);
    run_op("add_1_1", 0, 1, 1, 0);

    // Reset wins over a coincident out_ready while DONE.
    mode = 3'b100; DR = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check("rst_done_vld", 32'(out_valid), 0);
    check("rst_done_res", 32'(result), 0);

    for (int k = 0; k < 30; k++) begin
      int m, a, d;
      m = $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      d = (k % 5 == 0) ? 0 : $urandom_range(0, 255);
      run_op("rand", m, a, d, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port in_valid  input  1  operation request present.
REQ-005 Port in_ready  output  1  block can accept a request.
REQ-006 Port mode  input  3  operation select (encoding in REQ-014).
REQ-007 Port AC  input  WIDTH  accumulator operand.
REQ-008 Port DR  input  WIDTH  data-register operand.
REQ-009 Port out_valid  output  1  result, rem, E and Z are valid.
REQ-010 Port out_ready  input  1  consumer accepts the result.
REQ-011 Port result  output  WIDTH  operation result, registered.
REQ-012 Port rem  output  WIDTH  division remainder; 0 for all other ops.
REQ-013 Port E  output  1  extend/carry flag; Port Z  output  1  result==0 flag.

Function
REQ-014 The mode encoding SHALL be: 000 AC+DR; 001 DR arithmetic shift left 1; 010 ~(AC^DR); 011 DR logical shift right 1; 100 load DR; 101 store AC (result=AC); 110 two's complement of AC; 111 unsigned AC/DR (REQ-021).
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 A request SHALL be accepted on a cycle with in_valid=1 and in_ready=1; mode, AC and DR SHALL be latched on that edge and ignored afterwards.
REQ-017 Modes 000-110 SHALL go IDLE->DONE at acceptance; out_valid rises in the cycle after acceptance (latency 1).
REQ-018 DONE SHALL hold result, rem, E and Z stable until out_ready=1, then return to IDLE on that edge; the next request can be accepted no earlier than the following cycle.
REQ-019 E SHALL be: ADD carry-out of bit WIDTH; ASL old DR[WIDTH-1]; SHR old DR[0]; two's complement 1 iff AC==0; DIV 1 iff divide-by-zero; 0 otherwise.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; Z SHALL equal (result==0) for every mode.
REQ-021 Mode 111 with DR!=0 SHALL run restoring division for exactly WIDTH cycles in BUSY, then DONE; out_valid rises WIDTH+1 cycles after acceptance; result=quotient, rem=remainder.
REQ-022 Mode 111 with DR==0 SHALL skip BUSY: DONE after 1 cycle, result all ones, rem=AC, E=1.
REQ-023 in_valid SHALL be ignored while in BUSY or DONE; no request is queued.

Reset
REQ-024 While rst=1 the block SHALL enter IDLE and drive result=0, rem=0, E=0, Z=0, out_valid=0; in_ready=1 from the first cycle after rst deasserts.
REQ-025 rst asserted in BUSY or DONE SHALL abort the operation; the result is discarded and no out_valid pulse follows.
REQ-026 rst SHALL take priority over a coincident in_valid or out_ready.

Configuration
REQ-027 Macro ALU_SEQ_DIV_EN: when defined, mode 111 SHALL behave per REQ-021/REQ-022 and the BUSY state and divider datapath exist.
REQ-028 Without ALU_SEQ_DIV_EN, mode 111 SHALL complete with latency 1, result=0, rem=0, E=0, Z=1; BUSY is never entered and no divider logic is built.

Verification (WIDTH=8, ALU_SEQ_DIV_EN defined unless stated)
REQ-029 ADD AC=0xF0 DR=0x20 -> out_valid 1 cycle after accept, result=0x10, E=1, Z=0.
REQ-030 DIV AC=100 DR=7 -> in_ready=0 for 8 BUSY cycles, out_valid 9 cycles after accept, result=14, rem=2, E=0.
REQ-031 DIV AC=0x55 DR=0 -> out_valid 1 cycle after accept, result=0xFF, rem=0x55, E=1.
REQ-032 Two's complement AC=0x00 then ASL DR=0x81 with out_ready=0 for 5 cycles -> result 0x00/E=1/Z=1 held stable, in_ready=0 throughout; then result 0x02, E=1.
REQ-033 rst pulse at cycle 4 of DIV 200/3 -> out_valid never asserts, all outputs 0, next ADD 1+1 returns result=2.
REQ-034 ALU_SEQ_DIV_EN undefined: mode 111 AC=9 DR=3 -> latency 1, result=0, rem=0, E=0, Z=1.
